pwm_timer_multi: RTL and testbench
==================================

// Module: pwm_timer_multi
// PURPOSE
//  Parametrised timer/PWM generator: one shared prescaler, one period counter, CHANNELS compare outputs.
//  Modes: idle, periodic timer with sticky interrupt, edge-aligned PWM, center-aligned PWM.
//  Sits on the SoC peripheral bus behind a register file; drives motor/LED/door PWM pins and the timer IRQ.
// PARAMETERS
//  CHANNELS  4   number of compare/PWM channels
//  CNT_W     16  period counter and compare width
//  PRE_W     16  prescaler width
// PORTS
//  clk         in   1                clock
//  reset       in   1                reset, asynchronous, active-high
//  enable      in   1                run enable; low = idle behaviour
//  mode        in   2                00 idle, 01 timer, 10 edge PWM, 11 center PWM
//  prescaler   in   PRE_W            tick every prescaler+1 clocks
//  period      in   CNT_W            counter top value
//  compare     in   CHANNELS*CNT_W   channel i compare at [i*CNT_W +: CNT_W]
//  polarity    in   CHANNELS         1 = channel output inverted (active-low)
//  int_clr     in   1                clears timer_int
//  count       out  CNT_W            current counter value
//  pwm_out     out  CHANNELS         PWM outputs (registered)
//  timer_int   out  1                sticky interrupt flag
//  period_tick out  1                1-cycle pulse at each period boundary
// BEHAVIOUR
//  - Reset: count=0, pre_cnt=0, dir=up, pwm_out=0, timer_int=0, period_tick=0; shadows=0.
//  - Idle (mode 00 or enable=0): count, pre_cnt held 0, dir=up; pwm_out[i]=polarity[i]; period_tick=0.
//  - Mode or enable change (registered prev vs current): that cycle forces count=0, pre_cnt=0, dir=up,
//    timer_int=0; counting resumes the next cycle.
//  - Prescaler: pre_cnt counts 0..prescaler; tick when pre_cnt==prescaler, then pre_cnt=0.
//    prescaler=0 -> tick every clock. Counter advances only on tick.
//  - Modes 01/10: count 0..period; on tick at count>=period, count=0 (wrap) = boundary.
//  - Mode 11: up 0..period, then down to 0; dir flips on tick at count==period (->down)
//    and at count==0 (->up). Boundary = tick with count==0 and dir=down (valley).
//    period=0: count stays 0; every tick is a boundary.
//  - Boundary: period_tick=1 for that cycle; in modes 01..11 timer_int set. Set beats int_clr.
//  - timer_int stays 1 until int_clr (same-cycle set wins).
//  - PWM (10/11): pwm_out[i] = (cnt_next < cmp_i) ^ polarity[i], registered with count so
//    pwm_out matches the count value output in the same cycle. cmp=0 -> always inactive;
//    cmp>period -> always active. Mode 01: pwm_out[i]=polarity[i].
//  - All compares unsigned, CNT_W wide; count never exceeds max(period, value at live period drop).
// CONFIGURATION
//  PWM_TIMER_SHADOW_EN defined: period/compare used via shadow registers loaded while idle
//    (transparent) and on each boundary tick; mid-period writes take effect next period (glitch-free).
//  Not defined: period/compare used live; if period drops below count, the next tick wraps
//    (count>=period rule); compare changes act immediately.
// TESTING
//  - prescaler=0, period=4, mode 01 -> count 0,1,2,3,4,0; period_tick+timer_int on wrap; int_clr drops it.
//  - prescaler=2, period=3, mode 10, compare0=2 -> count steps every 3 clocks; pwm_out[0] high for count 0,1.
//  - mode 11, period=4, compare1=2, polarity1=1 -> count 0..4..0, pwm_out[1] low at count 0,1.
//  - compare=0 and compare=period+1 -> constant inactive / constant active across 3 periods.
//  - change mode 10->01 mid-period, and reset asserted mid-count -> count=0, outputs at reset values.
//  - SHADOW_EN: write period 9->5 at count 7 -> wraps at 9 once, then at 5; without macro wraps next tick.

Source files
------------

// File: rtl/pwm_timer_multi.sv
// Timer / PWM generator: shared prescaler, one period counter, CHANNELS compare outputs.
// Optional PWM_TIMER_SHADOW_EN: period/compare latched at idle and at each period boundary.
module pwm_timer_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRE_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [PRE_W-1:0]          prescaler,
    input  logic [CNT_W-1:0]          period,
    input  logic [CHANNELS*CNT_W-1:0] compare,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      int_clr,
    output logic [CNT_W-1:0]          count,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      timer_int,
    output logic                      period_tick
);

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_CENTER = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t                      dir_q, dir_next;
    logic [PRE_W-1:0]          pre_cnt, pre_next;
    logic [CNT_W-1:0]          cnt_next;
    logic [CHANNELS-1:0]       pwm_next;
    logic                      int_next;
    logic [1:0]                prev_mode;
    logic                      prev_enable;
    logic                      active, changed, tick, boundary;
    logic [CNT_W-1:0]          period_use;
    logic [CHANNELS*CNT_W-1:0] cmp_use;

    assign active  = enable && (mode != MODE_IDLE);
    assign changed = (mode != prev_mode) || (enable != prev_enable);
    // >= rather than == so a prescaler lowered below pre_cnt still ticks at once
    assign tick    = (pre_cnt >= prescaler);

`ifdef PWM_TIMER_SHADOW_EN
    logic [CNT_W-1:0]          period_sh;
    logic [CHANNELS*CNT_W-1:0] compare_sh;
    logic                      load_sh;

    assign load_sh    = changed || !active || boundary;
    assign period_use = period_sh;
    // On a load cycle the next count already belongs to the new period, so use the incoming compare.
    assign cmp_use    = load_sh ? compare : compare_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_sh  <= '0;
            compare_sh <= '0;
        end else if (load_sh) begin
            period_sh  <= period;
            compare_sh <= compare;
        end
    end
`else
    assign period_use = period;
    assign cmp_use    = compare;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q       <= DIR_UP;
            count       <= '0;
            pre_cnt     <= '0;
            pwm_out     <= '0;
            timer_int   <= 1'b0;
            period_tick <= 1'b0;
            prev_mode   <= MODE_IDLE;
            prev_enable <= 1'b0;
        end else begin
            dir_q       <= dir_next;
            count       <= cnt_next;
            pre_cnt     <= pre_next;
            pwm_out     <= pwm_next;
            timer_int   <= int_next;
            period_tick <= boundary;
            prev_mode   <= mode;
            prev_enable <= enable;
        end
    end

    always_comb begin
        cnt_next = count;
        pre_next = pre_cnt;
        dir_next = dir_q;
        boundary = 1'b0;
        if (changed || !active) begin
            cnt_next = '0;
            pre_next = '0;
            dir_next = DIR_UP;
        end else begin
            pre_next = tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                if (mode == MODE_CENTER) begin
                    if (period_use == '0) begin
                        cnt_next = '0;
                        boundary = 1'b1;
                    end else if (dir_q == DIR_UP) begin
                        if (count >= period_use) begin
                            dir_next = DIR_DOWN;
                            cnt_next = count - CNT_W'(1);
                        end else begin
                            cnt_next = count + CNT_W'(1);
                        end
                    end else begin
                        if (count == '0) begin
                            dir_next = DIR_UP;
                            boundary = 1'b1;
                            cnt_next = CNT_W'(1);
                        end else begin
                            cnt_next = count - CNT_W'(1);
                        end
                    end
                end else begin
                    if (count >= period_use) begin
                        cnt_next = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_next = count + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        if (changed)
            int_next = 1'b0;
        else if (boundary)
            int_next = 1'b1;
        else if (int_clr)
            int_next = 1'b0;
        else
            int_next = timer_int;
    end

    // Compare against the next count so pwm_out lines up with the registered count.
    always_comb begin
        pwm_next = polarity;
        for (int i = 0; i < CHANNELS; i++) begin
            if (active && mode[1])
                pwm_next[i] = (cnt_next < cmp_use[i*CNT_W +: CNT_W]) ^ polarity[i];
        end
    end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Self-checking bench for pwm_timer_multi: directed scenarios plus randomized configurations
// checked against a tick-count based reference model.
module tb_pwm_timer_multi;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int PW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic [PW-1:0]    prescaler;
    logic [CW-1:0]    period;
    logic [CH*CW-1:0] compare;
    logic [CH-1:0]    polarity;
    logic             int_clr;
    logic [CW-1:0]    count;
    logic [CH-1:0]    pwm_out;
    logic             timer_int;
    logic             period_tick;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_timer_multi #(.CHANNELS(CH), .CNT_W(CW), .PRE_W(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .prescaler(prescaler), .period(period), .compare(compare),
        .polarity(polarity), .int_clr(int_clr), .count(count),
        .pwm_out(pwm_out), .timer_int(timer_int), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: j = edges since the change cycle; ticks happen every prescaler+1 edges.
    function automatic int m_count(input logic [1:0] m, input int pre, input int per, input int j);
        int k, pos;
        k = j / (pre + 1);
        if (m == 2'b11) begin
            if (per == 0) return 0;
            pos = k % (2 * per);
            return (pos <= per) ? pos : 2 * per - pos;
        end
        return k % (per + 1);
    endfunction

    function automatic bit m_boundary(input logic [1:0] m, input int pre, input int per, input int j);
        int k;
        if (j == 0 || (j % (pre + 1)) != 0) return 1'b0;
        k = j / (pre + 1);
        if (m == 2'b11) begin
            if (per == 0) return 1'b1;
            return (k > 2 * per) && ((k % (2 * per)) == 1);
        end
        return (k % (per + 1)) == 0;
    endfunction

    task automatic run_cfg(input string name, input logic [1:0] m, input int pre, input int per,
                           input logic [CH*CW-1:0] cmp, input logic [CH-1:0] pol, input int ncyc);
        int             c, ci;
        bit             sticky, eb;
        logic [CH-1:0]  epwm;
        enable    = 1'b0;
        mode      = m;
        prescaler = PW'(pre);
        period    = CW'(per);
        compare   = cmp;
        polarity  = pol;
        int_clr   = 1'b0;
        step(); step(); step();
        n_checks++;
        if (count !== '0 || pwm_out !== pol || period_tick !== 1'b0 || timer_int !== 1'b0)
            $display("FAIL %s idle: count=%0d pwm=%b tick=%b int=%b, want 0 %b 0 0",
                     name, count, pwm_out, period_tick, timer_int, pol);
        else n_pass++;
        enable = 1'b1;
        sticky = 1'b0;
        for (int j = 0; j < ncyc; j++) begin
            step();
            c  = m_count(m, pre, per, j);
            eb = m_boundary(m, pre, per, j);
            sticky = sticky | eb;
            for (int i = 0; i < CH; i++) begin
                ci = int'(cmp[i*CW +: CW]);
                epwm[i] = m[1] ? ((c < ci) ^ pol[i]) : pol[i];
            end
            n_checks++;
            if (count !== CW'(c))
                $display("FAIL %s count j=%0d: got %0d want %0d", name, j, count, c);
            else n_pass++;
            n_checks++;
            if (pwm_out !== epwm)
                $display("FAIL %s pwm j=%0d: got %b want %b", name, j, pwm_out, epwm);
            else n_pass++;
            n_checks++;
            if (period_tick !== eb)
                $display("FAIL %s period_tick j=%0d: got %b want %b", name, j, period_tick, eb);
            else n_pass++;
            n_checks++;
            if (timer_int !== sticky)
                $display("FAIL %s timer_int j=%0d: got %b want %b", name, j, timer_int, sticky);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; mode = 2'b10; prescaler = '0; period = CW'(3);
        compare = '1; polarity = 4'hF; int_clr = 1'b0;
        step(); step();
        n_checks++;
        if (count !== '0 || pwm_out !== 4'h0 || timer_int !== 1'b0 || period_tick !== 1'b0)
            $display("FAIL reset_state: count=%0d pwm=%b int=%b tick=%b, want all 0",
                     count, pwm_out, timer_int, period_tick);
        else n_pass++;
        enable = 1'b0; mode = 2'b00;
        reset = 1'b0;
        step();
        n_checks++;
        if (count !== '0 || pwm_out !== 4'hF || period_tick !== 1'b0)
            $display("FAIL idle_after_reset: count=%0d pwm=%b tick=%b, want 0 1111 0",
                     count, pwm_out, period_tick);
        else n_pass++;
    endtask

    task automatic test_timer_int();
        int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
        enable = 1'b0; mode = 2'b01; prescaler = '0; period = CW'(4);
        compare = '0; polarity = 4'b0110; int_clr = 1'b0;
        step(); step();
        enable = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            n_checks++;
            if (count !== CW'(exp_seq[j]))
                $display("FAIL timer_count j=%0d: got %0d want %0d", j, count, exp_seq[j]);
            else n_pass++;
        end
        n_checks++;
        if (period_tick !== 1'b1 || timer_int !== 1'b1 || pwm_out !== 4'b0110)
            $display("FAIL timer_wrap: tick=%b int=%b pwm=%b, want 1 1 0110", period_tick, timer_int, pwm_out);
        else n_pass++;
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        n_checks++;
        if (timer_int !== 1'b0 || period_tick !== 1'b0 || count !== CW'(1))
            $display("FAIL int_clr: int=%b tick=%b count=%0d, want 0 0 1", timer_int, period_tick, count);
        else n_pass++;
        step(); step(); step();
        int_clr = 1'b1;
        step();
        n_checks++;
        if (timer_int !== 1'b1 || period_tick !== 1'b1 || count !== '0)
            $display("FAIL set_beats_clr: int=%b tick=%b count=%0d, want 1 1 0", timer_int, period_tick, count);
        else n_pass++;
        step();
        int_clr = 1'b0;
        n_checks++;
        if (timer_int !== 1'b0)
            $display("FAIL clr_after_set: int=%b want 0", timer_int);
        else n_pass++;
    endtask

    task automatic test_mode_change_and_reset();
        enable = 1'b0; mode = 2'b10; prescaler = '0; period = CW'(2);
        compare = {16'd0, 16'd0, 16'd0, 16'd2}; polarity = 4'b1001; int_clr = 1'b0;
        step(); step();
        enable = 1'b1;
        for (int j = 0; j < 5; j++) step();
        n_checks++;
        if (count !== CW'(1) || timer_int !== 1'b1 || pwm_out !== 4'b1000)
            $display("FAIL pre_change: count=%0d int=%b pwm=%b, want 1 1 1000", count, timer_int, pwm_out);
        else n_pass++;
        mode = 2'b01;
        step();
        n_checks++;
        if (count !== '0 || timer_int !== 1'b0 || pwm_out !== 4'b1001 || period_tick !== 1'b0)
            $display("FAIL mode_change: count=%0d int=%b pwm=%b tick=%b, want 0 0 1001 0",
                     count, timer_int, pwm_out, period_tick);
        else n_pass++;
        step();
        n_checks++;
        if (count !== CW'(1))
            $display("FAIL resume_after_change: count=%0d want 1", count);
        else n_pass++;
        step(); step(); step();
        n_checks++;
        if (count !== CW'(1) || timer_int !== 1'b1)
            $display("FAIL pre_reset: count=%0d int=%b, want 1 1", count, timer_int);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (count !== '0 || pwm_out !== 4'h0 || timer_int !== 1'b0 || period_tick !== 1'b0)
            $display("FAIL async_reset: count=%0d pwm=%b int=%b tick=%b, want all 0",
                     count, pwm_out, timer_int, period_tick);
        else n_pass++;
        step();
        enable = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_period_drop();
        enable = 1'b0; mode = 2'b01; prescaler = '0; period = CW'(9);
        compare = '0; polarity = '0; int_clr = 1'b0;
        step(); step();
        enable = 1'b1;
        for (int j = 0; j < 8; j++) step();
        n_checks++;
        if (count !== CW'(7))
            $display("FAIL drop_setup: count=%0d want 7", count);
        else n_pass++;
        period = CW'(5);
`ifdef PWM_TIMER_SHADOW_EN
        step(); step(); step();
        n_checks++;
        if (count !== '0 || period_tick !== 1'b1)
            $display("FAIL shadow_old_wrap: count=%0d tick=%b, want 0 1", count, period_tick);
        else n_pass++;
`else
        step();
        n_checks++;
        if (count !== '0 || period_tick !== 1'b1)
            $display("FAIL live_drop_wrap: count=%0d tick=%b, want 0 1", count, period_tick);
        else n_pass++;
`endif
        for (int j = 0; j < 5; j++) step();
        n_checks++;
        if (count !== CW'(5) || period_tick !== 1'b0)
            $display("FAIL new_period_top: count=%0d tick=%b, want 5 0", count, period_tick);
        else n_pass++;
        step();
        n_checks++;
        if (count !== '0 || period_tick !== 1'b1)
            $display("FAIL new_period_wrap: count=%0d tick=%b, want 0 1", count, period_tick);
        else n_pass++;
    endtask

    task automatic test_directed_pwm();
        run_cfg("timer_basic", 2'b01, 0, 4, {16'd1, 16'd2, 16'd3, 16'd4}, 4'b0101, 12);
        run_cfg("edge_prescale", 2'b10, 2, 3, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0000, 30);
        run_cfg("center_pol", 2'b11, 0, 4, {16'd0, 16'd0, 16'd2, 16'd3}, 4'b0010, 20);
        run_cfg("edge_limits", 2'b10, 1, 3, {16'd2, 16'd1, 16'd4, 16'd0}, 4'b0100, 26);
        run_cfg("center_limits", 2'b11, 0, 3, {16'd2, 16'd1, 16'd4, 16'd0}, 4'b1000, 22);
        run_cfg("center_p0", 2'b11, 1, 0, {16'd0, 16'd0, 16'd1, 16'd0}, 4'b0001, 8);
    endtask

    task automatic test_random();
        logic [1:0]       m;
        int               pre, per;
        logic [CH*CW-1:0] cmp;
        logic [CH-1:0]    pol;
        for (int t = 0; t < 8; t++) begin
            m   = 2'($urandom_range(1, 3));
            pre = $urandom_range(0, 3);
            per = $urandom_range(0, 7);
            for (int i = 0; i < CH; i++)
                cmp[i*CW +: CW] = CW'($urandom_range(0, per + 2));
            pol = CH'($urandom_range(0, 15));
            run_cfg("random", m, pre, per, cmp, pol, (pre + 1) * (2 * per + 3) + 4);
        end
    endtask

    initial begin
        test_reset();
        test_timer_int();
        test_mode_change_and_reset();
        test_period_drop();
        test_directed_pwm();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
